// File: rtl/d_mem_arbiter_pkg.sv
// Shared data-memory definitions plus the arbiter state encoding.
// Imported by the D_MEM arbiter and its testbench.
package d_mem_arbiter_pkg;

    localparam int BITS     = 32;
    localparam int ADDRW    = 11;
    localparam int CP_LEN_W = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_data_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/d_mem_arbiter.sv
// Shares the single D_MEM port between the CPU MEM stage and the image coprocessor.
// CPU has priority; a starvation counter forces a coprocessor grant, and bursts run one word per cycle.
module d_mem_arbiter
    import d_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LEN_W        = CP_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [BITS-1:0]  cpu_wdata,
    input  mem_data_t        cpu_type,
    output logic [BITS-1:0]  cpu_rdata,
    output logic             cpu_stall,

    input  logic             cp_req,
    input  logic             cp_wr,
    input  logic [ADDRW-1:0] cp_base,
    input  logic [LEN_W-1:0] cp_len,
    input  logic [BITS-1:0]  cp_wdata,
    output logic             cp_gnt,
    output logic             cp_beat,
    output logic             cp_done,
    output logic [BITS-1:0]  cp_rdata,
    output logic             cp_rvalid,

    output logic [ADDRW-1:0] MEM_ADDR,
    output logic [BITS-1:0]  MEM_DATA_IN,
    output logic             MEM_WRITE,
    output logic             MEM_READ,
    output mem_data_t        MEM_DATA_TYPE,
    input  logic [BITS-1:0]  MEM_DATA_OUT
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wr_q, wr_d;
    logic [ADDRW-3:0] base_q, base_d;
    logic             rvalid_q;
    logic [BITS-1:0]  rdata_q;

    logic             cpuAccess;
    logic             grant;
    logic             lastBeat;
    logic             memWr;
    logic             memRd;
    logic [ADDRW-3:0] beatWord;

    assign cpuAccess = cpu_rd | cpu_wr;
    // Word address arithmetic wraps naturally at the top of the address space.
    assign beatWord  = base_q + (ADDRW-2)'(beat_q);

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        beat_d        = beat_q;
        len_d         = len_q;
        wr_d          = wr_q;
        base_d        = base_q;
        grant         = 1'b0;
        lastBeat      = 1'b0;
        MEM_ADDR      = cpu_addr;
        MEM_DATA_IN   = cpu_wdata;
        MEM_DATA_TYPE = WORD;
        memWr         = 1'b0;
        memRd         = 1'b0;
        cpu_rdata     = '0;
        cpu_stall     = 1'b0;
        cp_gnt        = 1'b0;
        cp_beat       = 1'b0;
        cp_done       = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                memWr     = cpu_wr;
                memRd     = cpu_rd;
                cpu_rdata = MEM_DATA_OUT;
                if (cpuAccess) begin
                    MEM_DATA_TYPE = cpu_type;
                end
                grant = cp_req && (!cpuAccess || starve_q == STARVE_MAX);
                if (grant) begin
                    starve_d = '0;
                    state_d  = ARB_BURST;
                    wr_d     = cp_wr;
                    base_d   = cp_base[ADDRW-1:2];
                    len_d    = cp_len;
                    beat_d   = '0;
                end else if (cp_req && cpuAccess && starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            ARB_BURST: begin
                MEM_ADDR    = {beatWord, 2'b00};
                MEM_DATA_IN = cp_wdata;
                memWr       = wr_q;
                memRd       = !wr_q;
                cp_beat     = 1'b1;
                cp_gnt      = (beat_q == '0);
                cpu_stall   = cpuAccess;
                lastBeat    = (beat_q == len_q);
                cp_done     = lastBeat;
                if (lastBeat) begin
                    state_d = ARB_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Memory strobes are held off for the whole time reset is asserted.
    assign MEM_WRITE = memWr & rst_n;
    assign MEM_READ  = memRd & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            wr_q     <= 1'b0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            wr_q     <= wr_d;
            base_q   <= base_d;
        end
    end

    // Read beats return their word one cycle later as a contiguous stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= (state_q == ARB_BURST) && !wr_q;
            if ((state_q == ARB_BURST) && !wr_q) begin
                rdata_q <= MEM_DATA_OUT;
            end
        end
    end

    assign cp_rvalid = rvalid_q;
    assign cp_rdata  = rdata_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter: a behavioural D_MEM plus a reference word store
// predict every CPU load, burst address, beat flag and returned read word.
module tb_d_mem_arbiter;
    import d_mem_arbiter_pkg::*;

    localparam int SL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_rd, cpu_wr;
    logic [ADDRW-1:0] cpu_addr;
    logic [BITS-1:0]  cpu_wdata;
    mem_data_t        cpu_type;
    logic [BITS-1:0]  cpu_rdata;
    logic             cpu_stall;
    logic             cp_req, cp_wr;
    logic [ADDRW-1:0] cp_base;
    logic [3:0]       cp_len;
    logic [BITS-1:0]  cp_wdata;
    logic             cp_gnt, cp_beat, cp_done, cp_rvalid;
    logic [BITS-1:0]  cp_rdata;
    logic [ADDRW-1:0] MEM_ADDR;
    logic [BITS-1:0]  MEM_DATA_IN;
    logic             MEM_WRITE, MEM_READ;
    mem_data_t        MEM_DATA_TYPE;
    logic [BITS-1:0]  MEM_DATA_OUT;

    logic [BITS-1:0]  dmem   [512];
    logic [BITS-1:0]  refMem [512];

    int nCompared   = 0;
    int nMismatched = 0;

    d_mem_arbiter #(.STARVE_LIMIT(SL), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_type(cpu_type), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cp_req(cp_req), .cp_wr(cp_wr), .cp_base(cp_base), .cp_len(cp_len),
        .cp_wdata(cp_wdata), .cp_gnt(cp_gnt), .cp_beat(cp_beat), .cp_done(cp_done),
        .cp_rdata(cp_rdata), .cp_rvalid(cp_rvalid),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN), .MEM_WRITE(MEM_WRITE),
        .MEM_READ(MEM_READ), .MEM_DATA_TYPE(MEM_DATA_TYPE), .MEM_DATA_OUT(MEM_DATA_OUT)
    );

    always #5 clk = ~clk;

    // Word-only D_MEM stand-in: combinational read, write on the clock edge.
    assign MEM_DATA_OUT = dmem[MEM_ADDR[ADDRW-1:2]];
    always @(posedge clk) begin
        if (MEM_WRITE) dmem[MEM_ADDR[ADDRW-1:2]] <= MEM_DATA_IN;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDRW-1:0] addr,
                                 input logic [BITS-1:0] wdata);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_type  = WORD;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic [ADDRW-1:0] addr, input logic [BITS-1:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
        @(negedge clk);
        checkOutput("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cpu_wr_strobe", 32'(MEM_WRITE), 32'd1);
        @(posedge clk);
        refMem[addr[ADDRW-1:2]] = data;
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic cpuRead(input logic [ADDRW-1:0] addr);
        applyStimulus(1'b1, 1'b0, addr, '0);
        @(negedge clk);
        checkOutput("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cpu_rd_data", cpu_rdata, refMem[addr[ADDRW-1:2]]);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    // Runs a burst with an idle CPU; grant is expected to be decided in the first cycle.
    task automatic doBurst(input logic wr, input logic [ADDRW-1:0] base, input int len,
                           input logic idxData);
        logic [8:0] w, prevW;
        prevW   = '0;
        cp_req  = 1'b1;
        cp_wr   = wr;
        cp_base = base;
        cp_len  = 4'(len);
        @(negedge clk);
        checkOutput("burst_pre_beat", 32'(cp_beat), 32'd0);
        tick();
        cp_req  = 1'b0;
        cp_wr   = ~wr;
        cp_base = ADDRW'($urandom);
        cp_len  = 4'($urandom);
        for (int k = 0; k <= len; k++) begin
            cp_wdata = idxData ? 32'hA0 + 32'(k) : $urandom;
            w = base[ADDRW-1:2] + 9'(k);
            @(negedge clk);
            checkOutput("beat_flag", 32'(cp_beat), 32'd1);
            checkOutput("beat_gnt", 32'(cp_gnt), 32'(k == 0));
            checkOutput("beat_done", 32'(cp_done), 32'(k == len));
            checkOutput("beat_addr", 32'(MEM_ADDR), 32'({w, 2'b00}));
            checkOutput("beat_write", 32'(MEM_WRITE), 32'(wr));
            checkOutput("beat_read", 32'(MEM_READ), 32'(!wr));
            checkOutput("beat_type", 32'(MEM_DATA_TYPE), 32'(WORD));
            checkOutput("beat_rvalid", 32'(cp_rvalid), 32'(!wr && k > 0));
            if (!wr && k > 0) checkOutput("beat_rdata", cp_rdata, refMem[prevW]);
            @(posedge clk);
            if (wr) refMem[w] = cp_wdata;
            #1;
            prevW = w;
        end
        @(negedge clk);
        checkOutput("post_beat", 32'(cp_beat), 32'd0);
        checkOutput("post_rvalid", 32'(cp_rvalid), 32'(!wr));
        if (!wr) checkOutput("post_rdata", cp_rdata, refMem[prevW]);
        tick();
    endtask

    initial begin
        logic [ADDRW-1:0] a;
        for (int i = 0; i < 512; i++) refMem[i] = '0;
        applyStimulus(1'b1, 1'b0, '0, '0);
        cp_req = 1'b1; cp_wr = 1'b0; cp_base = '0; cp_len = '0; cp_wdata = '0;

        rst_n = 1'b0;
        #12;
        checkOutput("rst_gnt", 32'(cp_gnt), 32'd0);
        checkOutput("rst_beat", 32'(cp_beat), 32'd0);
        checkOutput("rst_done", 32'(cp_done), 32'd0);
        checkOutput("rst_rvalid", 32'(cp_rvalid), 32'd0);
        checkOutput("rst_rdata", cp_rdata, 32'd0);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rst_memread", 32'(MEM_READ), 32'd0);
        checkOutput("rst_memwrite", 32'(MEM_WRITE), 32'd0);
        cp_req = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // CPU-only traffic over words 0..396.
        for (int i = 0; i <= 396; i++) cpuWrite(ADDRW'(i * 4), $urandom);
        for (int i = 0; i <= 396; i++) cpuRead(ADDRW'(i * 4));

        // Write burst with index-derived data, then CPU readback.
        doBurst(1'b1, 11'h100, 3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            a = 11'h100 + ADDRW'(k * 4);
            cpuRead(a);
            checkOutput("wrburst_pattern", refMem[a[ADDRW-1:2]], 32'hA0 + 32'(k));
        end

        // Sixteen-word read burst over freshly written words.
        for (int k = 0; k < 16; k++) cpuWrite(11'h100 + ADDRW'(k * 4), $urandom);
        doBurst(1'b0, 11'h100, 15, 1'b0);

        // Starvation: CPU loads every cycle while the coprocessor waits.
        cp_req = 1'b1; cp_wr = 1'b0; cp_base = 11'h200; cp_len = 4'd3;
        for (int c = 0; c <= SL + 5; c++) begin
            a = ADDRW'($urandom_range(0, 396) * 4);
            applyStimulus(1'b1, 1'b0, a, '0);
            @(negedge clk);
            if (c <= SL || c == SL + 5) begin
                checkOutput("starve_cpu_stall", 32'(cpu_stall), 32'd0);
                checkOutput("starve_cpu_beat", 32'(cp_beat), 32'd0);
                checkOutput("starve_cpu_data", cpu_rdata, refMem[a[ADDRW-1:2]]);
            end else begin
                checkOutput("starve_burst_stall", 32'(cpu_stall), 32'd1);
                checkOutput("starve_burst_beat", 32'(cp_beat), 32'd1);
                checkOutput("starve_burst_gnt", 32'(cp_gnt), 32'(c == SL + 1));
                checkOutput("starve_burst_done", 32'(cp_done), 32'(c == SL + 4));
                checkOutput("starve_burst_rdata", cpu_rdata, 32'd0);
                checkOutput("starve_burst_addr", 32'(MEM_ADDR), 32'h200 + 32'((c - SL - 1) * 4));
            end
            tick();
        end
        cp_req = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();

        // Address wrap with low base bits set.
        doBurst(1'b1, 11'h7FB, 3, 1'b0);
        cpuRead(11'h7F8);
        cpuRead(11'h7FC);
        cpuRead(11'h000);
        cpuRead(11'h004);

        // Reset during beat 2 of an 8-word write burst.
        for (int k = 0; k < 8; k++) cpuWrite(11'h300 + ADDRW'(k * 4), $urandom);
        cp_req = 1'b1; cp_wr = 1'b1; cp_base = 11'h300; cp_len = 4'd7;
        tick();
        cp_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cp_wdata = $urandom;
            @(posedge clk);
            refMem[9'h0C0 + 9'(k)] = cp_wdata;
            #1;
        end
        cp_wdata = $urandom;
        @(negedge clk);
        checkOutput("abort_pre_beat", 32'(cp_beat), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_beat", 32'(cp_beat), 32'd0);
        checkOutput("abort_gnt", 32'(cp_gnt), 32'd0);
        checkOutput("abort_done", 32'(cp_done), 32'd0);
        checkOutput("abort_write", 32'(MEM_WRITE), 32'd0);
        checkOutput("abort_read", 32'(MEM_READ), 32'd0);
        checkOutput("abort_rvalid", 32'(cp_rvalid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_abort_beat", 32'(cp_beat), 32'd0);
        checkOutput("after_abort_done", 32'(cp_done), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) cpuRead(11'h300 + ADDRW'(k * 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/d_mem_arbiter.md
# d_mem_arbiter

Two-port arbiter and sequencer placed directly in front of D_MEM: shares the single data-memory port between the CPU MEM stage (single-cycle load/store) and the image coprocessor (word bursts). CPU has priority. A starvation counter guarantees the coprocessor a grant. Bursts are sequenced beat-by-beat with generated word addresses.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles the CPU may win while cp_req is pending before the coprocessor is force-granted (legal range 1..15).
- LEN_W, 4: width of cp_len; burst length = cp_len + 1 words (1..16).

Ports (clock and reset: one clock, reset asynchronous active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_rd, cpu_wr  in  1 each  CPU load / store request (never both high)
- cpu_addr  in  ADDRW  CPU byte address
- cpu_wdata  in  BITS  CPU store data
- cpu_type  in  mem_data_t  CPU access type
- cpu_rdata  out  BITS  load data, valid in the same cycle as cpu_rd when cpu_stall=0
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds request
- cp_req  in  1  coprocessor burst request
- cp_wr  in  1  burst direction (1 = write); sampled with cp_base/cp_len at grant
- cp_base  in  ADDRW  burst start byte address; bits [1:0] ignored
- cp_len  in  LEN_W  burst length minus one
- cp_wdata  in  BITS  write data for the current beat; must be valid while cp_beat=1
- cp_gnt  out  1  high in the first beat cycle of a burst
- cp_beat  out  1  a burst beat is being issued to memory this cycle
- cp_done  out  1  high in the last beat cycle
- cp_rdata  out  BITS  registered read data
- cp_rvalid  out  1  cp_rdata valid; one cycle after each read beat
- MEM_ADDR, MEM_DATA_IN, MEM_WRITE, MEM_READ, MEM_DATA_TYPE  out  D_MEM widths  memory command
- MEM_DATA_OUT  in  BITS  D_MEM combinational read data

## Operation
- FSM states: IDLE, BURST.
- IDLE: the memory port is a combinational pass-through of the CPU port. cpu_stall=0. cpu_rdata=MEM_DATA_OUT.
- starve_cnt increments in IDLE when cp_req=1 and a CPU access occurs. It saturates at STARVE_LIMIT and clears on grant.
- Grant condition in IDLE: cp_req=1 AND (no CPU access OR starve_cnt==STARVE_LIMIT).
- On grant: latch cp_wr, cp_base[ADDRW-1:2], cp_len, clear beat_idx, and go to BURST at the next edge. The CPU access in the deciding cycle is still served.
- BURST: one beat per cycle.
  - MEM_ADDR = {base_word + beat_idx, 2'b00}, wrapping modulo 2^ADDRW.
  - MEM_DATA_TYPE=WORD, MEM_WRITE=latched wr, MEM_READ=!wr, MEM_DATA_IN=cp_wdata.
  - cp_beat=1. cpu_stall = cpu_rd|cpu_wr. cpu_rdata=0.
- Last beat (beat_idx==latched len): cp_done=1, next state IDLE.
- cp_req level during BURST is ignored; the burst always completes.
- A back-to-back burst can be granted only from IDLE, so there is at least one IDLE cycle between bursts.
- After a grant, starve_cnt=0. A pending CPU access therefore always wins the cycle after a burst (STARVE_LIMIT ≥ 1).
- Idle memory port: MEM_READ=MEM_WRITE=0, MEM_DATA_TYPE=WORD, MEM_ADDR=cpu_addr.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE; starve_cnt, beat_idx and latched fields 0.
  - cp_gnt, cp_beat, cp_done, cp_rvalid = 0; cp_rdata=0; cpu_stall=0.
  - MEM_WRITE and MEM_READ forced 0 while rst_n is low.
- Reset mid-burst aborts the burst; no cp_done is issued.
- Grant latency: cp_req seen in IDLE with the grant condition true → first beat (cp_gnt=1) in the next cycle.
- Burst of N words occupies exactly N consecutive cycles.
- Read beat k → cp_rvalid=1 and cp_rdata=word k in cycle k+1. The rvalid stream is contiguous.
- CPU read latency: 0 cycles when not stalled.
- CPU write takes effect at the clock edge ending its unstalled cycle.

## Structure
- common_params gains typedef enum arb_state_t {ARB_IDLE, ARB_BURST} and the constant CP_LEN_W=4.
- Reuse mem_data_t, BITS and ADDRW from common_params.
- Single module; no sub-module needed. The starve counter and beat counter are inline registers.

## Test plan
- CPU only: store words 0..396 then load them back. Expect cpu_stall never asserted and data matches; pattern identical to the D_MEM word test.
- Coprocessor idle-CPU write burst: cp_base=0x100, cp_len=3, cp_wdata=beat index+0xA0.
  - cp_gnt next cycle; beats at 0x100,0x104,0x108,0x10C; cp_done on the 4th beat.
  - A follow-up CPU loads return 0xA0..0xA3.
- Read burst of 16 from 0x100 after writing known words: cp_rvalid for 16 consecutive cycles starting one cycle after cp_gnt, data in order.
- Starvation: CPU issues back-to-back loads with cp_req held high.
  - Grant occurs after exactly STARVE_LIMIT=4 CPU cycles.
  - cpu_stall=1 for all burst cycles; the CPU wins the cycle after cp_done.
- Wrap: cp_base = 2^ADDRW-8, cp_len=3. Addresses go 2^ADDRW-8, -4, 0x0, 0x4; cp_base[1:0]=2'b11 is ignored.
- Reset asserted on beat 2 of 8: all outputs 0 immediately; state IDLE after release; no cp_done; memory beyond beat 1 unmodified.
